// File: rtl/vga_sync_gen.sv
// VGA raster timing: free-running column/row counters with registered active-region
// strobes, porch-timed active-low connector syncs and line/frame ticks.
module vga_sync_gen #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int COL_W         = $clog2(TOTAL_COLS),
  parameter int ROW_W         = $clog2(TOTAL_ROWS)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [COL_W-1:0] o_col_count,
  output logic [ROW_W-1:0] o_row_count,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_vga_hsync,
  output logic             o_vga_vsync,
  output logic             o_line_tick,
  output logic             o_frame_tick
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [31:0] H_ACT   = 32'(ACTIVE_COLS);
  localparam logic [31:0] V_ACT   = 32'(ACTIVE_ROWS);
  localparam logic [31:0] HS_LO   = 32'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [31:0] HS_HI   = 32'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [31:0] VS_LO   = 32'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [31:0] VS_HI   = 32'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

  // Window bounds can equal the total count, which may not fit in the counter
  // width, so decoding is done on zero-extended 32-bit values.
  function automatic logic in_window(input logic [31:0] v,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic             col_wrap;
  logic [COL_W-1:0] col_p0;
  logic [ROW_W-1:0] row_p0;
  logic             hsync_p0;
  logic             vsync_p0;
  logic             vga_hsync_p0;
  logic             vga_vsync_p0;
  logic             line_tick_p0;
  logic             frame_tick_p0;

  // p0: next-state counters and the outputs decoded from them
  always_comb begin
    col_wrap = (o_col_count == COL_LAST);
    col_p0   = col_wrap ? '0 : o_col_count + COL_W'(1);
    row_p0   = o_row_count;
    if (col_wrap) begin
      row_p0 = (o_row_count == ROW_LAST) ? '0 : o_row_count + ROW_W'(1);
    end
    hsync_p0      = 32'(col_p0) < H_ACT;
    vsync_p0      = 32'(row_p0) < V_ACT;
    vga_hsync_p0  = !in_window(32'(col_p0), HS_LO, HS_HI);
    vga_vsync_p0  = !in_window(32'(row_p0), VS_LO, VS_HI);
    line_tick_p0  = (col_p0 == '0);
    frame_tick_p0 = (col_p0 == '0) && (row_p0 == '0);
  end

  // p1: registered outputs; a disabled edge holds levels and clears ticks
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_col_count  <= COL_LAST;
      o_row_count  <= ROW_LAST;
      o_hsync      <= 1'b0;
      o_vsync      <= 1'b0;
      o_vga_hsync  <= 1'b1;
      o_vga_vsync  <= 1'b1;
      o_line_tick  <= 1'b0;
      o_frame_tick <= 1'b0;
    end else if (i_en) begin
      o_col_count  <= col_p0;
      o_row_count  <= row_p0;
      o_hsync      <= hsync_p0;
      o_vsync      <= vsync_p0;
      o_vga_hsync  <= vga_hsync_p0;
      o_vga_vsync  <= vga_vsync_p0;
      o_line_tick  <= line_tick_p0;
      o_frame_tick <= frame_tick_p0;
    end else begin
      o_line_tick  <= 1'b0;
      o_frame_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 800x525 instance for line timing and
// async reset, and a 10x4 instance for frame-level, enable-hold and period checks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst_n = 1'b0, d_en = 1'b1;
  logic [9:0] d_col, d_row;
  logic       d_hs, d_vs, d_gh, d_gv, d_line, d_frame;

  logic       s_rst_n = 1'b0, s_en = 1'b0;
  logic [3:0] s_col;
  logic [1:0] s_row;
  logic       s_hs, s_vs, s_gh, s_gv, s_line, s_frame;

  vga_sync_gen dut_d (
    .clk(clk), .i_rst_n(d_rst_n), .i_en(d_en),
    .o_col_count(d_col), .o_row_count(d_row),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_vga_hsync(d_gh), .o_vga_vsync(d_gv),
    .o_line_tick(d_line), .o_frame_tick(d_frame)
  );

  vga_sync_gen #(
    .TOTAL_COLS(10), .TOTAL_ROWS(4), .ACTIVE_COLS(6), .ACTIVE_ROWS(2),
    .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1),
    .COL_W(4), .ROW_W(2)
  ) dut_s (
    .clk(clk), .i_rst_n(s_rst_n), .i_en(s_en),
    .o_col_count(s_col), .o_row_count(s_row),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_vga_hsync(s_gh), .o_vga_vsync(s_gv),
    .o_line_tick(s_line), .o_frame_tick(s_frame)
  );

  int checks = 0;
  int errors = 0;

  // flags = {hsync, vsync, vga_hsync, vga_vsync, line_tick, frame_tick}
  typedef struct {
    int         adv;
    int         col;
    int         row;
    logic [5:0] flags;
  } vec_t;

  vec_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int gc, input int gr, input logic [5:0] gf,
                     input int ec, input int er, input logic [5:0] ef);
    checks++;
    if (gc != ec || gr != er || gf !== ef) begin
      errors++;
      $display("FAIL %s: got col=%0d row=%0d flags=%b, expected col=%0d row=%0d flags=%b",
               name, gc, gr, gf, ec, er, ef);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [5:0] dexp(input int c, input int r);
    return {c < 640, r < 480, !(c >= 656 && c < 752), !(r >= 490 && r < 492),
            c == 0, c == 0 && r == 0};
  endfunction

  function automatic logic [5:0] dflags();
    return {d_hs, d_vs, d_gh, d_gv, d_line, d_frame};
  endfunction

  function automatic logic [5:0] sflags();
    return {s_hs, s_vs, s_gh, s_gv, s_line, s_frame};
  endfunction

  initial begin
    int gh_low;
    int cnt;

    tbl[0]  = '{1,  0, 0, 6'b111111};
    tbl[1]  = '{1,  1, 0, 6'b111100};
    tbl[2]  = '{4,  5, 0, 6'b111100};
    tbl[3]  = '{1,  6, 0, 6'b011100};
    tbl[4]  = '{1,  7, 0, 6'b010100};
    tbl[5]  = '{1,  8, 0, 6'b010100};
    tbl[6]  = '{1,  9, 0, 6'b011100};
    tbl[7]  = '{1,  0, 1, 6'b111110};
    tbl[8]  = '{10, 0, 2, 6'b101110};
    tbl[9]  = '{9,  9, 2, 6'b001100};
    tbl[10] = '{1,  0, 3, 6'b101010};
    tbl[11] = '{7,  7, 3, 6'b000000};
    tbl[12] = '{2,  9, 3, 6'b001000};
    tbl[13] = '{1,  0, 0, 6'b111111};

    // Reset state of both instances
    step();
    step();
    chk("d_reset", d_col, d_row, dflags(), 799, 524, 6'b001100);
    chk("s_reset", s_col, s_row, sflags(), 9, 3, 6'b001100);

    // Release; small instance stays disabled and must hold reset values
    d_rst_n = 1'b1;
    s_rst_n = 1'b1;
    step();
    chk("d_first", d_col, d_row, dflags(), 0, 0, 6'b111111);
    chk("s_idle", s_col, s_row, sflags(), 9, 3, 6'b001100);
    step();
    chk("d_second", d_col, d_row, dflags(), 1, 0, 6'b111100);

    // One full line on the default instance
    gh_low = 0;
    for (int k = 2; k <= 800; k++) begin
      step();
      chk($sformatf("d_line_k%0d", k), d_col, d_row, dflags(), k % 800, k / 800,
          dexp(k % 800, k / 800));
      if (!d_gh) gh_low++;
    end
    chk_int("d_vga_hsync_low_cycles", gh_low, 96);

    // Advance to (300,1), then assert reset between edges
    for (int k = 0; k < 300; k++) step();
    chk("d_at_300_1", d_col, d_row, dflags(), 300, 1, dexp(300, 1));
    #2;
    d_rst_n = 1'b0;
    #1;
    chk("d_async_reset", d_col, d_row, dflags(), 799, 524, 6'b001100);
    #1;
    d_rst_n = 1'b1;
    step();
    chk("d_after_reset", d_col, d_row, dflags(), 0, 0, 6'b111111);
    d_en = 1'b0;

    // Small instance: full frame from table
    s_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      for (int a = 0; a < tbl[i].adv; a++) step();
      chk($sformatf("s_tbl%0d", i), s_col, s_row, sflags(), tbl[i].col, tbl[i].row,
          tbl[i].flags);
    end

    // Enable dropped at the frame start: hold position, ticks cleared
    s_en = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      chk($sformatf("s_hold%0d", k), s_col, s_row, sflags(), 0, 0, 6'b111100);
    end
    s_en = 1'b1;
    step();
    chk("s_resume", s_col, s_row, sflags(), 1, 0, 6'b111100);

    // Frame tick period
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!s_frame && cnt < 100);
    chk_int("s_to_frame_tick", cnt, 39);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!s_frame && cnt < 100);
    chk_int("s_frame_period", cnt, 40);
    chk("s_frame_pos", s_col, s_row, sflags(), 0, 0, 6'b111111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
